cc_lut_load_ctrl: RTL and testbench

- Sequences LUT reloads for the colour-correction block.
- Captures a 768-byte LUT packet from the I2C byte receiver into an internal staging RAM and checks its length.
- Replays a good packet as an SOP/EOP/VLD/packet_data burst, only inside vertical blanking of the monitored video stream, so no frame is processed with a half-written LUT.

---
 rtl/cc_lut_load_ctrl_if.sv | 36 +++
 rtl/cc_lut_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_cc_lut_load_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_lut_load_ctrl_if.sv
// LUT loader bus: I2C byte receiver in, monitored video stream in,
// LUT burst and status out.
interface cc_lut_load_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_start;
    logic       rx_stop;
    logic       s_axis_tvalid;
    logic       s_axis_tuser;
    logic       s_axis_tlast;
    logic       err_clr;
    logic       SOP;
    logic       EOP;
    logic       VLD;
    logic [7:0] packet_data;
    logic       busy;
    logic       pending;
    logic       load_done;
    logic       len_err;
    logic       ovr_err;
    logic       tear_err;

    modport master (
        output rx_valid, rx_data, rx_start, rx_stop,
        output s_axis_tvalid, s_axis_tuser, s_axis_tlast, err_clr,
        input  SOP, EOP, VLD, packet_data, busy, pending, load_done,
        input  len_err, ovr_err, tear_err
    );

    modport slave (
        input  rx_valid, rx_data, rx_start, rx_stop,
        input  s_axis_tvalid, s_axis_tuser, s_axis_tlast, err_clr,
        output SOP, EOP, VLD, packet_data, busy, pending, load_done,
        output len_err, ovr_err, tear_err
    );
endinterface

// File: rtl/cc_lut_load_ctrl.sv
// Captures an I2C LUT packet into staging RAM, then replays it as a burst
// only during vertical blanking so no frame sees a half-written LUT.
module cc_lut_load_ctrl #(
    parameter int LUT_BYTES       = 768,
    parameter int LINES_PER_FRAME = 1080,
    parameter int LINE_W          = 11
) (
    input  logic              clk,
    input  logic              rst,
    cc_lut_load_ctrl_if.slave bus
);
    localparam int AW = $clog2(LUT_BYTES);
    localparam int CW = $clog2(LUT_BYTES + 2);

    typedef enum logic [1:0] {IDLE, CAPTURE, PENDING, LOAD} state_t;

    state_t             r_state;
    logic [7:0]         r_mem [LUT_BYTES];
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      r_rd_cnt;
    logic [LINE_W-1:0]  r_line;
    logic [7:0]         r_data;
    logic               r_sop, r_eop, r_vld, r_busy, r_pending, r_done;
    logic               r_len_err, r_ovr_err, r_tear_err;

    logic               w_start, w_blank, w_we;
    logic               w_len_set, w_ovr_set, w_tear_set;
    logic [AW-1:0]      w_waddr;
    logic [CW-1:0]      w_cnt_nxt;

    assign w_start   = bus.rx_valid & bus.rx_start;
    assign w_blank   = (r_line == LINE_W'(LINES_PER_FRAME));
    assign w_cnt_nxt = (r_cnt == CW'(LUT_BYTES + 1)) ? r_cnt : r_cnt + CW'(1);

    assign w_len_set  = (r_state != LOAD) &&
                        ((w_start && bus.rx_stop) ||
                         (r_state == CAPTURE && bus.rx_valid && !bus.rx_start &&
                          bus.rx_stop && w_cnt_nxt != CW'(LUT_BYTES)));
    assign w_ovr_set  = (r_state == LOAD) && w_start;
    assign w_tear_set = (r_state == LOAD) && bus.s_axis_tvalid && bus.s_axis_tuser;

    // Bytes beyond LUT_BYTES are counted for the length check but never stored
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        if (w_start && r_state != LOAD) begin
            w_we = 1'b1;
        end else if (r_state == CAPTURE && bus.rx_valid && r_cnt < CW'(LUT_BYTES)) begin
            w_we    = 1'b1;
            w_waddr = AW'(r_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= bus.rx_data;
    end

    // Start-of-frame wins over a same-beat end-of-line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else if (bus.s_axis_tvalid && bus.s_axis_tuser) begin
            r_line <= '0;
        end else if (bus.s_axis_tvalid && bus.s_axis_tlast && !w_blank) begin
            r_line <= r_line + LINE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd_cnt   <= '0;
            r_data     <= '0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_vld      <= 1'b0;
            r_busy     <= 1'b0;
            r_pending  <= 1'b0;
            r_done     <= 1'b0;
            r_len_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
            r_tear_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_data <= '0;
            case (r_state)
                IDLE, CAPTURE, PENDING: begin
                    if (w_start) begin
                        r_cnt     <= CW'(1);
                        r_pending <= 1'b0;
                        r_state   <= bus.rx_stop ? IDLE : CAPTURE;
                    end else if (r_state == CAPTURE && bus.rx_valid) begin
                        r_cnt <= w_cnt_nxt;
                        if (bus.rx_stop) begin
                            if (w_cnt_nxt == CW'(LUT_BYTES)) begin
                                r_state   <= PENDING;
                                r_pending <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end else if (r_state == PENDING && w_blank) begin
                        r_state   <= LOAD;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_rd_cnt  <= '0;
                    end
                end
                LOAD: begin
                    // One-cycle read latency: address k read here shows as beat k next cycle
                    if (r_rd_cnt < CW'(LUT_BYTES)) begin
                        r_vld    <= 1'b1;
                        r_sop    <= (r_rd_cnt == '0);
                        r_eop    <= (r_rd_cnt == CW'(LUT_BYTES - 1));
                        r_data   <= r_mem[AW'(r_rd_cnt)];
                        r_rd_cnt <= r_rd_cnt + CW'(1);
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            r_len_err  <= (r_len_err  & ~bus.err_clr) | w_len_set;
            r_ovr_err  <= (r_ovr_err  & ~bus.err_clr) | w_ovr_set;
            r_tear_err <= (r_tear_err & ~bus.err_clr) | w_tear_set;
        end
    end

    assign bus.SOP         = r_sop;
    assign bus.EOP         = r_eop;
    assign bus.VLD         = r_vld;
    assign bus.packet_data = r_data;
    assign bus.busy        = r_busy;
    assign bus.pending     = r_pending;
    assign bus.load_done   = r_done;
    assign bus.len_err     = r_len_err;
    assign bus.ovr_err     = r_ovr_err;
    assign bus.tear_err    = r_tear_err;
endmodule

// File: tb/tb_cc_lut_load_ctrl.sv
// Scoreboard bench for cc_lut_load_ctrl: packets push expected beats, a
// negedge monitor pops and compares every burst beat.
module tb_cc_lut_load_ctrl;
    localparam int LUT_BYTES = 768;
    localparam int LPF       = 1080;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cc_lut_load_ctrl_if bus();

    cc_lut_load_ctrl #(.LUT_BYTES(LUT_BYTES), .LINES_PER_FRAME(LPF), .LINE_W(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] d;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    sop_cyc = 0;
    int    beats   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        int t;
        case (kind)
            0:       t = i;
            1:       t = i * 7 + 3;
            default: t = 255 - i;
        endcase
        return t[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (bus.VLD) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vld", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {22'd0, bus.SOP, bus.EOP, bus.packet_data}, {22'd0, mon_e});
                end
                if (bus.SOP) begin
                    sop_cyc = cyc;
                    beats   = 0;
                end
                beats++;
            end else begin
                chk("idle_bus", {22'd0, bus.SOP, bus.EOP, bus.packet_data}, 32'd0);
            end
            if (bus.load_done) begin
                chk("done_latency", cyc - sop_cyc, LUT_BYTES);
                chk("done_beats", beats, LUT_BYTES);
                chk("done_busy_low", bus.busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input int kind, input bit expect_burst);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = pat(kind, i);
            bus.rx_start = (i == 0);
            bus.rx_stop  = (i == len - 1);
            if (expect_burst) begin
                b.sop = (i == 0);
                b.eop = (i == len - 1);
                b.d   = pat(kind, i);
                exp_q.push_back(b);
            end
            tick();
        end
        bus.rx_valid = 1'b0;
        bus.rx_start = 1'b0;
        bus.rx_stop  = 1'b0;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = 1'b1;
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic sof();
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tuser  = 1'b1;
        tick();
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 1'b0;
    endtask

    task automatic clr_errs();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("errs_cleared", {bus.len_err, bus.ovr_err, bus.tear_err}, 0);
    endtask

    // Cycles between the triggering edge and the first VLD beat
    task automatic wait_first_vld(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.VLD && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, 2);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.load_done && n < 900) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.load_done, 1);
        tick();
        chk("idle_after_done", {bus.busy, bus.pending}, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_start = 0; bus.rx_stop = 0;
        bus.s_axis_tvalid = 0; bus.s_axis_tuser = 0; bus.s_axis_tlast = 0;
        bus.err_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {bus.SOP, bus.EOP, bus.VLD, bus.packet_data, bus.busy, bus.pending,
                           bus.load_done, bus.len_err, bus.ovr_err, bus.tear_err}, 0);
        rst = 1'b0;
        tick();

        // Good packet while already in blanking
        sof();
        lines(LPF);
        send_pkt(LUT_BYTES, 0, 1);
        chk("s1_pending", bus.pending, 1);
        wait_first_vld("s1_latency");
        wait_done();
        chk("s1_no_errs", {bus.len_err, bus.ovr_err, bus.tear_err}, 0);

        // Packet completes mid-frame, waits for blanking
        sof();
        lines(500);
        send_pkt(LUT_BYTES, 1, 1);
        chk("s2_pending", bus.pending, 1);
        lines(LPF - 501);
        chk("s2_still_pending", {bus.pending, bus.busy, bus.VLD}, 3'b100);
        lines(1);
        wait_first_vld("s2_latency");
        wait_done();

        // Length errors, no burst even though blanking is active
        send_pkt(LUT_BYTES - 1, 0, 0);
        chk("s3_short_len_err", {bus.len_err, bus.pending, bus.busy}, 3'b100);
        repeat (5) tick();
        clr_errs();
        send_pkt(LUT_BYTES + 1, 0, 0);
        chk("s3_long_len_err", {bus.len_err, bus.pending, bus.busy}, 3'b100);
        repeat (5) tick();
        clr_errs();
        bus.err_clr = 1'b1;
        send_pkt(1, 0, 0);
        bus.err_clr = 1'b0;
        chk("s3_one_byte_set_wins", {bus.len_err, bus.pending}, 2'b10);
        clr_errs();

        // Start-of-frame mid-burst: burst completes, tear flagged
        send_pkt(LUT_BYTES, 2, 1);
        wait_first_vld("s4_latency");
        repeat (299) tick();
        sof();
        chk("s4_tear", {bus.tear_err, bus.busy}, 2'b11);
        wait_done();
        chk("s4_tear_sticky", bus.tear_err, 1);
        clr_errs();

        // Restart in PENDING; start during LOAD is flagged and dropped
        send_pkt(LUT_BYTES, 1, 0);
        chk("s5_pending_a", bus.pending, 1);
        send_pkt(LUT_BYTES, 2, 1);
        chk("s5_pending_b", bus.pending, 1);
        lines(LPF);
        wait_first_vld("s5_latency");
        repeat (50) tick();
        send_pkt(10, 0, 0);
        chk("s5_ovr", {bus.ovr_err, bus.len_err, bus.busy}, 3'b101);
        wait_done();
        clr_errs();

        // Async reset during the burst
        send_pkt(LUT_BYTES, 0, 1);
        wait_first_vld("s6_latency");
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_async", {bus.VLD, bus.SOP, bus.EOP, bus.busy, bus.packet_data}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("s6_after_rst", {bus.busy, bus.pending, bus.VLD, bus.load_done}, 0);
        send_pkt(LUT_BYTES, 1, 1);
        repeat (20) tick();
        chk("s6_no_blank_after_rst", {bus.pending, bus.busy}, 2'b10);
        sof();
        lines(LPF);
        wait_first_vld("s6_reload_latency");
        wait_done();
        chk("s6_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
